// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU/branch/jump instructions, snoops the
// ALU and load/store CDBs for missing operands, and issues the lowest-index ready entry each cycle.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clr,
    input  logic             disp_s,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_s,
    input  logic             disp_qk_s,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [ROB_W-1:0] disp_reorder,
    input  logic [31:0]      disp_a,
    input  logic [31:0]      disp_pc,
    output logic             rs_full,
    input  logic             cdb_alu_s,
    input  logic [ROB_W-1:0] cdb_alu_reorder,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_s,
    input  logic [ROB_W-1:0] cdb_lsb_reorder,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_s,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_vj,
    output logic [31:0]      alu_vk,
    output logic [ROB_W-1:0] alu_reorder,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_pc
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_reg, busy_next;
    logic [RS_SIZE-1:0] qj_s_reg, qk_s_reg;
    logic [OP_W-1:0]    op_reg      [RS_SIZE];
    logic [31:0]        vj_reg      [RS_SIZE];
    logic [31:0]        vk_reg      [RS_SIZE];
    logic [ROB_W-1:0]   qj_reg      [RS_SIZE];
    logic [ROB_W-1:0]   qk_reg      [RS_SIZE];
    logic [ROB_W-1:0]   reorder_reg [RS_SIZE];
    logic [31:0]        a_reg       [RS_SIZE];
    logic [31:0]        pc_reg      [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;
    logic [IDX_W-1:0]   free_idx, issue_idx;
    logic               issue_found, disp_we;

    // Per-entry readiness and CDB tag matches, all from pre-edge registered state
    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            assign ready_vec[gi] = busy_reg[gi] & ~qj_s_reg[gi] & ~qk_s_reg[gi];
            assign j_alu_hit[gi] = qj_s_reg[gi] && cdb_alu_s && (cdb_alu_reorder == qj_reg[gi]);
            assign j_lsb_hit[gi] = qj_s_reg[gi] && cdb_lsb_s && (cdb_lsb_reorder == qj_reg[gi]);
            assign k_alu_hit[gi] = qk_s_reg[gi] && cdb_alu_s && (cdb_alu_reorder == qk_reg[gi]);
            assign k_lsb_hit[gi] = qk_s_reg[gi] && cdb_lsb_s && (cdb_lsb_reorder == qk_reg[gi]);
        end
    endgenerate

    assign rs_full     = &busy_reg;
    assign issue_found = |ready_vec;
    assign disp_we     = disp_s && !rs_full;

    // Lowest-index priority encoders: scanning downward lets the lowest match win
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_reg[i])
                free_idx = IDX_W'(i);
            if (ready_vec[i])
                issue_idx = IDX_W'(i);
        end
    end

    // Issue slot is always busy and the free slot never is, so the two updates never collide
    always_comb begin
        busy_next = busy_reg;
        if (issue_found)
            busy_next[issue_idx] = 1'b0;
        if (disp_we)
            busy_next[free_idx] = 1'b1;
    end

    // Dispatch-time forwarding from the CDBs; the ALU bus takes precedence
    logic        fwd_qj_s, fwd_qk_s;
    logic [31:0] fwd_vj, fwd_vk;
    always_comb begin
        fwd_qj_s = disp_qj_s;
        fwd_vj   = disp_vj;
        fwd_qk_s = disp_qk_s;
        fwd_vk   = disp_vk;
        if (disp_qj_s && cdb_alu_s && cdb_alu_reorder == disp_qj) begin
            fwd_qj_s = 1'b0;
            fwd_vj   = cdb_alu_value;
        end else if (disp_qj_s && cdb_lsb_s && cdb_lsb_reorder == disp_qj) begin
            fwd_qj_s = 1'b0;
            fwd_vj   = cdb_lsb_value;
        end
        if (disp_qk_s && cdb_alu_s && cdb_alu_reorder == disp_qk) begin
            fwd_qk_s = 1'b0;
            fwd_vk   = cdb_alu_value;
        end else if (disp_qk_s && cdb_lsb_s && cdb_lsb_reorder == disp_qk) begin
            fwd_qk_s = 1'b0;
            fwd_vk   = cdb_lsb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg    <= '0;
            alu_s       <= 1'b0;
            alu_op      <= '0;
            alu_vj      <= '0;
            alu_vk      <= '0;
            alu_reorder <= '0;
            alu_a       <= '0;
            alu_pc      <= '0;
        end else if (rdy) begin
            if (clr) begin
                busy_reg <= '0;
                alu_s    <= 1'b0;
            end else begin
                busy_reg <= busy_next;
                alu_s    <= issue_found;
                if (issue_found) begin
                    alu_op      <= op_reg[issue_idx];
                    alu_vj      <= vj_reg[issue_idx];
                    alu_vk      <= vk_reg[issue_idx];
                    alu_reorder <= reorder_reg[issue_idx];
                    alu_a       <= a_reg[issue_idx];
                    alu_pc      <= pc_reg[issue_idx];
                end
            end
        end
    end

    // Entry payloads need no reset: busy gates every use of them
    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_we && free_idx == IDX_W'(i)) begin
                    op_reg[i]      <= disp_op;
                    vj_reg[i]      <= fwd_vj;
                    vk_reg[i]      <= fwd_vk;
                    qj_s_reg[i]    <= fwd_qj_s;
                    qk_s_reg[i]    <= fwd_qk_s;
                    qj_reg[i]      <= disp_qj;
                    qk_reg[i]      <= disp_qk;
                    reorder_reg[i] <= disp_reorder;
                    a_reg[i]       <= disp_a;
                    pc_reg[i]      <= disp_pc;
                end else if (busy_reg[i]) begin
                    if (j_alu_hit[i]) begin
                        vj_reg[i]   <= cdb_alu_value;
                        qj_s_reg[i] <= 1'b0;
                    end else if (j_lsb_hit[i]) begin
                        vj_reg[i]   <= cdb_lsb_value;
                        qj_s_reg[i] <= 1'b0;
                    end
                    if (k_alu_hit[i]) begin
                        vk_reg[i]   <= cdb_alu_value;
                        qk_s_reg[i] <= 1'b0;
                    end else if (k_lsb_hit[i]) begin
                        vk_reg[i]   <= cdb_lsb_value;
                        qk_s_reg[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: reset, wakeup, forwarding, fill/drain, flush, stall.
module tb_alu_rs;
    localparam int RS_SIZE = 16;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 6;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd10;

    logic             clk, rst, rdy, clr;
    logic             disp_s, disp_qj_s, disp_qk_s;
    logic [OP_W-1:0]  disp_op;
    logic [31:0]      disp_vj, disp_vk, disp_a, disp_pc;
    logic [ROB_W-1:0] disp_qj, disp_qk, disp_reorder;
    logic             rs_full;
    logic             cdb_alu_s, cdb_lsb_s;
    logic [ROB_W-1:0] cdb_alu_reorder, cdb_lsb_reorder;
    logic [31:0]      cdb_alu_value, cdb_lsb_value;
    logic             alu_s;
    logic [OP_W-1:0]  alu_op;
    logic [31:0]      alu_vj, alu_vk, alu_a, alu_pc;
    logic [ROB_W-1:0] alu_reorder;

    int checks = 0;
    int errors = 0;

    alu_rs #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .disp_s(disp_s), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_s(disp_qj_s), .disp_qk_s(disp_qk_s), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_reorder(disp_reorder), .disp_a(disp_a), .disp_pc(disp_pc), .rs_full(rs_full),
        .cdb_alu_s(cdb_alu_s), .cdb_alu_reorder(cdb_alu_reorder), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_s(cdb_lsb_s), .cdb_lsb_reorder(cdb_lsb_reorder), .cdb_lsb_value(cdb_lsb_value),
        .alu_s(alu_s), .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk),
        .alu_reorder(alu_reorder), .alu_a(alu_a), .alu_pc(alu_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjs, input logic [ROB_W-1:0] qj,
                        input logic qks, input logic [ROB_W-1:0] qk,
                        input logic [ROB_W-1:0] tag, input logic [31:0] a, input logic [31:0] pc);
        disp_s = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj_s = qjs; disp_qj = qj; disp_qk_s = qks; disp_qk = qk;
        disp_reorder = tag; disp_a = a; disp_pc = pc;
        $display("dispatch op=%0d tag=%0d qj_s=%0b qj=%0d qk_s=%0b qk=%0d", op, tag, qjs, qj, qks, qk);
    endtask

    task automatic cdb_alu(input logic s, input logic [ROB_W-1:0] tag, input logic [31:0] val);
        cdb_alu_s = s; cdb_alu_reorder = tag; cdb_alu_value = val;
    endtask

    task automatic cdb_lsb(input logic s, input logic [ROB_W-1:0] tag, input logic [31:0] val);
        cdb_lsb_s = s; cdb_lsb_reorder = tag; cdb_lsb_value = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        disp_s = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj_s = 1'b0; disp_qk_s = 1'b0; disp_qj = '0; disp_qk = '0;
        disp_reorder = '0; disp_a = '0; disp_pc = '0;
        cdb_alu(1'b0, '0, '0);
        cdb_lsb(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset_alu_s", 32'(alu_s), 32'd0);
        check("reset_rs_full", 32'(rs_full), 32'd0);
        check("reset_alu_vj", alu_vj, 32'd0);
        rst = 1'b1;

        // Mid-operation async reset with 5 busy entries and a live issue
        for (int i = 0; i < 5; i++) begin
            disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'(10 + i), 32'd0, 32'h40);
            step();
        end
        disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'd0, 32'h44);
        step();
        disp_s = 1'b0;
        step();
        check("pre_reset_issue_s", 32'(alu_s), 32'd1);
        check("pre_reset_issue_tag", 32'(alu_reorder), 32'd9);
        #2 rst = 1'b0;
        #1;
        check("async_reset_alu_s", 32'(alu_s), 32'd0);
        check("async_reset_rs_full", 32'(rs_full), 32'd0);
        check("async_reset_alu_reorder", 32'(alu_reorder), 32'd0);
        check("async_reset_alu_pc", alu_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cdb_alu(1'b1, 4'd15, 32'd1);
        step();
        cdb_alu(1'b0, '0, '0);
        check("post_reset_no_issue_a", 32'(alu_s), 32'd0);
        step();
        check("post_reset_no_issue_b", 32'(alu_s), 32'd0);

        // Ready at dispatch: issue one edge later, never same edge
        disp(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'd0, 32'h100);
        step();
        disp_s = 1'b0;
        check("add_no_bypass", 32'(alu_s), 32'd0);
        step();
        check("add_alu_s", 32'(alu_s), 32'd1);
        check("add_vj", alu_vj, 32'd3);
        check("add_vk", alu_vk, 32'd4);
        check("add_reorder", 32'(alu_reorder), 32'd2);
        check("add_op", 32'(alu_op), 32'(OP_ADD));
        check("add_pc", alu_pc, 32'h100);
        step();
        check("add_single_issue", 32'(alu_s), 32'd0);

        // ADDI waiting on tag 5, woken by the load/store CDB
        disp(OP_ADDI, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd3, 32'd7, 32'h104);
        step();
        disp_s = 1'b0;
        step();
        check("addi_waiting", 32'(alu_s), 32'd0);
        cdb_lsb(1'b1, 4'd5, 32'h10);
        step();
        cdb_lsb(1'b0, '0, '0);
        check("addi_wake_no_bypass", 32'(alu_s), 32'd0);
        step();
        check("addi_alu_s", 32'(alu_s), 32'd1);
        check("addi_vj", alu_vj, 32'h10);
        check("addi_a", alu_a, 32'd7);
        check("addi_reorder", 32'(alu_reorder), 32'd3);
        step();

        // Dispatch-time forwarding from the ALU CDB
        disp(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd5, 1'b0, 4'd0, 4'd6, 32'd0, 32'h108);
        cdb_alu(1'b1, 4'd5, 32'd9);
        step();
        disp_s = 1'b0;
        cdb_alu(1'b0, '0, '0);
        check("fwd_no_bypass", 32'(alu_s), 32'd0);
        step();
        check("fwd_alu_s", 32'(alu_s), 32'd1);
        check("fwd_vj", alu_vj, 32'd9);
        check("fwd_vk", alu_vk, 32'd2);
        step();

        // j and k woken together from different buses; both buses on one tag: ALU wins
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd3, 4'd7, 32'd0, 32'h10c);
        step();
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6, 4'd8, 32'd0, 32'h110);
        cdb_alu(1'b1, 4'd2, 32'd1);
        cdb_lsb(1'b1, 4'd3, 32'd2);
        step();
        disp_s = 1'b0;
        cdb_alu(1'b1, 4'd6, 32'hA);
        cdb_lsb(1'b1, 4'd6, 32'hB);
        step();
        cdb_alu(1'b0, '0, '0);
        cdb_lsb(1'b0, '0, '0);
        check("split_wake_reorder", 32'(alu_reorder), 32'd7);
        check("split_wake_vj", alu_vj, 32'd1);
        check("split_wake_vk", alu_vk, 32'd2);
        step();
        check("alu_prio_reorder", 32'(alu_reorder), 32'd8);
        check("alu_prio_vj", alu_vj, 32'hA);
        check("alu_prio_vk", alu_vk, 32'hA);
        step();

        // Fill all entries waiting on tag 1, drain in index order
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i), 32'd0, 32'(32'h200 + 4 * i));
            step();
        end
        disp_s = 1'b0;
        check("fill_rs_full", 32'(rs_full), 32'd1);
        disp(OP_ADD, 32'hdead, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14, 32'd0, 32'h300);
        step();
        disp_s = 1'b0;
        check("overflow_rs_full", 32'(rs_full), 32'd1);
        check("overflow_no_issue_a", 32'(alu_s), 32'd0);
        step();
        check("overflow_no_issue_b", 32'(alu_s), 32'd0);
        cdb_alu(1'b1, 4'd1, 32'h55);
        step();
        cdb_alu(1'b0, '0, '0);
        check("drain_wake_no_bypass", 32'(alu_s), 32'd0);
        check("drain_full_before_issue", 32'(rs_full), 32'd1);
        for (int k = 0; k < RS_SIZE; k++) begin
            step();
            check($sformatf("drain_s_%0d", k), 32'(alu_s), 32'd1);
            check($sformatf("drain_reorder_%0d", k), 32'(alu_reorder), 32'(k));
            check($sformatf("drain_vj_%0d", k), alu_vj, 32'h55);
            check($sformatf("drain_vk_%0d", k), alu_vk, 32'(k));
            if (k == 0)
                check("drain_rs_full_drop", 32'(rs_full), 32'd0);
        end
        step();
        check("drain_done", 32'(alu_s), 32'd0);

        // Flush with 3 busy entries (one ready to issue) and a same-cycle dispatch
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd1, 32'd0, 32'h400);
        step();
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd2, 32'd0, 32'h404);
        step();
        disp(OP_ADD, 32'd6, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 32'd0, 32'h408);
        step();
        disp(OP_ADD, 32'd4, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 32'd0, 32'h40c);
        clr = 1'b1;
        cdb_alu(1'b1, 4'd7, 32'h77);
        step();
        clr = 1'b0;
        disp_s = 1'b0;
        cdb_alu(1'b0, '0, '0);
        check("clr_alu_s", 32'(alu_s), 32'd0);
        check("clr_rs_full", 32'(rs_full), 32'd0);
        step();
        check("clr_disp_discarded", 32'(alu_s), 32'd0);
        cdb_alu(1'b1, 4'd7, 32'h77);
        step();
        cdb_alu(1'b0, '0, '0);
        check("clr_late_wake_a", 32'(alu_s), 32'd0);
        step();
        check("clr_late_wake_b", 32'(alu_s), 32'd0);

        // Stall: rdy=0 freezes outputs and entries; wakeup during stall is lost
        disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd8, 1'b0, 4'd0, 4'd4, 32'd0, 32'h500);
        step();
        disp(OP_ADD, 32'h33, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'd0, 32'h504);
        step();
        disp_s = 1'b0;
        step();
        check("stall_pre_s", 32'(alu_s), 32'd1);
        check("stall_pre_reorder", 32'(alu_reorder), 32'd3);
        rdy = 1'b0;
        cdb_alu(1'b1, 4'd8, 32'h88);
        disp(OP_ADD, 32'h99, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'd0, 32'h508);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("stall_s_%0d", c), 32'(alu_s), 32'd1);
            check($sformatf("stall_reorder_%0d", c), 32'(alu_reorder), 32'd3);
            check($sformatf("stall_vj_%0d", c), alu_vj, 32'h33);
        end
        rdy = 1'b1;
        disp_s = 1'b0;
        cdb_alu(1'b0, '0, '0);
        step();
        check("resume_missed_wake", 32'(alu_s), 32'd0);
        cdb_alu(1'b1, 4'd8, 32'h88);
        step();
        cdb_alu(1'b0, '0, '0);
        check("resume_wake_no_bypass", 32'(alu_s), 32'd0);
        step();
        check("resume_issue_s", 32'(alu_s), 32'd1);
        check("resume_issue_reorder", 32'(alu_reorder), 32'd4);
        check("resume_issue_vj", alu_vj, 32'h88);
        step();
        check("stall_disp_ignored", 32'(alu_s), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
